// File: rtl/xrv_pkg.sv
// xrv shared definitions for the M-extension issue path.
// Opcodes, FSM state type and default datapath width.
package xrv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MUL,
        WAIT_DIV,
        RESP
    } md_state_t;

    // funct3[2] selects the divider family
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/xrv_muldiv_issue_if.sv
// Request/response handshake bundle between execute/writeback
// and the M-extension issue controller.
interface xrv_muldiv_issue_if
    import xrv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_optype;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic [4:0]      rsp_rd;

    modport master (
        output req_valid, req_optype, req_a, req_b, req_rd,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_rd
    );

    modport slave (
        input  req_valid, req_optype, req_a, req_b, req_rd,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_result, rsp_rd
    );

endinterface

// File: rtl/xrv_muldiv_issue.sv
// Issue controller for xrv_mult / xrv_div: accepts one M-op,
// pulses the chosen unit, waits for its result and hands it back.
module xrv_muldiv_issue
    import xrv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rstb,
    xrv_muldiv_issue_if.slave io,
    input  logic            flush,
    output logic            busy,
    output logic            err,
    output logic            mul_valid,
    output logic [2:0]      mul_optype,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_result,
    input  logic            mul_result_valid,
    output logic            div_valid,
    output logic [2:0]      div_optype,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_result_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    md_state_t       state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic            mul_v_q;
    logic            div_v_q;
    logic            rsp_v_q;
    logic [XLEN-1:0] res_q;
    logic            drop_q;
    logic            err_q;
    logic [TW-1:0]   timer_q;

    logic            accept;
    logic            in_wait;
    logic            unit_rv;
    logic [XLEN-1:0] unit_res;
    logic            tmo_hit;
    logic            finish;

    assign io.req_ready  = (state == IDLE);
    assign accept        = io.req_valid & io.req_ready & ~flush;
    assign in_wait       = (state == WAIT_MUL) | (state == WAIT_DIV);
    assign tmo_hit       = in_wait & ~unit_rv & (timer_q == TLIM);
    assign finish        = in_wait & (unit_rv | tmo_hit);

    assign busy          = (state != IDLE);
    assign err           = err_q;
    assign io.rsp_valid  = rsp_v_q;
    assign io.rsp_result = res_q;
    assign io.rsp_rd     = rd_q;
    assign mul_valid     = mul_v_q;
    assign div_valid     = div_v_q;
    assign mul_optype    = op_q;
    assign div_optype    = op_q;
    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign div_dividend  = a_q;
    assign div_divisor   = b_q;

    // only the unit we are waiting on may complete the op
    always_comb begin
        unit_rv  = 1'b0;
        unit_res = '0;
        unique case (1'b1)
            state == WAIT_MUL: begin
                unit_rv  = mul_result_valid;
                unit_res = mul_result;
            end
            state == WAIT_DIV: begin
                unit_rv  = div_result_valid;
                unit_res = div_result;
            end
            default: ;
        endcase
    end

    // operand/tag capture; held until the next accept
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
        end else if (accept) begin
            op_q <= io.req_optype;
            a_q  <= io.req_a;
            b_q  <= io.req_b;
            rd_q <= io.req_rd;
        end
    end

    // control FSM, issue pulses and response register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            mul_v_q <= 1'b0;
            div_v_q <= 1'b0;
            rsp_v_q <= 1'b0;
            res_q   <= '0;
        end else begin
            mul_v_q <= 1'b0;
            div_v_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mul_v_q <= ~op_is_div(io.req_optype);
                        div_v_q <= op_is_div(io.req_optype);
                        state   <= op_is_div(io.req_optype)
                                   ? WAIT_DIV : WAIT_MUL;
                    end
                end
                WAIT_MUL, WAIT_DIV: begin
                    if (finish) begin
                        res_q <= tmo_hit ? '0 : unit_res;
                        if (drop_q || flush) begin
                            state <= IDLE;
                        end else begin
                            state   <= RESP;
                            rsp_v_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (flush || io.rsp_ready) begin
                        rsp_v_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // wait timer, flush-drop marker and sticky timeout error
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            timer_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept || finish) begin
                timer_q <= '0;
                drop_q  <= 1'b0;
            end else if (in_wait) begin
                timer_q <= timer_q + 1'b1;
                if (flush) drop_q <= 1'b1;
            end
            if (tmo_hit) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xrv_muldiv_issue.sv
// Randomised self-checking bench for xrv_muldiv_issue with
// behavioural mult/div stubs and an arithmetic reference model.
module tb_xrv_muldiv_issue;
    import xrv_pkg::*;

    localparam int XL = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic flush;
    logic busy, err;
    logic mul_valid, div_valid;
    logic [2:0] mul_optype, div_optype;
    logic [XL-1:0] mul_a, mul_b, div_dividend, div_divisor;
    logic [XL-1:0] mul_result, div_result;
    logic mul_result_valid, div_result_valid;

    xrv_muldiv_issue_if #(.XLEN(XL)) ifc ();

    xrv_muldiv_issue #(.XLEN(XL), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rstb             (rstb),
        .io               (ifc),
        .flush            (flush),
        .busy             (busy),
        .err              (err),
        .mul_valid        (mul_valid),
        .mul_optype       (mul_optype),
        .mul_a            (mul_a),
        .mul_b            (mul_b),
        .mul_result       (mul_result),
        .mul_result_valid (mul_result_valid),
        .div_valid        (div_valid),
        .div_optype       (div_optype),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_result       (div_result),
        .div_result_valid (div_result_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int mul_lat = 1, div_lat = 1;
    int mul_cnt, div_cnt;
    bit div_hang = 0;
    bit spur_mul = 0, spur_div = 0;
    int mul_pulses = 0, div_pulses = 0;
    logic [XL-1:0] mul_pend, div_pend;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics
    function automatic logic [XL-1:0] ref_md(input logic [2:0] op,
                                             input logic [XL-1:0] a,
                                             input logic [XL-1:0] b);
        logic signed [63:0] sa, sb, ubs, ps;
        logic [63:0] pu;
        logic signed [31:0] as_, bs_;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ubs = {32'b0, b};
        as_ = a;
        bs_ = b;
        case (op)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * ubs; return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return as_ / bs_;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                return as_ % bs_;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // multiplier stub: fixed latency, optional stray strobe
    always @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            mul_cnt = 0;
            mul_result_valid = 1'b0;
            mul_result = '0;
        end else begin
            mul_result_valid = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_result_valid = 1'b1;
                    mul_result = mul_pend;
                end
            end else if (spur_mul) begin
                mul_result_valid = 1'b1;
                mul_result = 32'hDEADBEEF;
                spur_mul = 0;
            end
            if (mul_valid) begin
                mul_pulses++;
                mul_cnt = mul_lat;
                mul_pend = ref_md(mul_optype, mul_a, mul_b);
            end
        end
    end

    // divider stub: fixed latency, can be told to never answer
    always @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt = 0;
            div_result_valid = 1'b0;
            div_result = '0;
        end else begin
            div_result_valid = 1'b0;
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    div_result_valid = 1'b1;
                    div_result = div_pend;
                end
            end else if (spur_div) begin
                div_result_valid = 1'b1;
                div_result = 32'hBAADF00D;
                spur_div = 0;
            end
            if (div_valid) begin
                div_pulses++;
                if (!div_hang) div_cnt = div_lat;
                div_pend = ref_md(div_optype, div_dividend, div_divisor);
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input int lat);
        @(negedge clk);
        chk("req_ready_idle", ifc.req_ready, 1);
        mul_lat = lat;
        div_lat = lat;
        ifc.req_valid  = 1'b1;
        ifc.req_optype = op;
        ifc.req_a      = a;
        ifc.req_b      = b;
        ifc.req_rd     = rd;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("issue_pulse", op[2] ? div_valid : mul_valid, 1);
        chk("issue_other", op[2] ? mul_valid : div_valid, 0);
        chk("issue_a", mul_a, a);
        chk("issue_b", op[2] ? div_divisor : mul_b, b);
        chk("issue_op", op[2] ? div_optype : mul_optype, op);
        chk("busy_wait", busy, 1);
    endtask

    task automatic finish_rsp();
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        chk("rsp_drop", ifc.rsp_valid, 0);
        chk("ready_back", ifc.req_ready, 1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int lat, input int rdelay, input bit spur);
        int k;
        bit rr_bad, hold_ok;
        int mp0, dp0;
        logic [31:0] r0;
        logic [4:0] d0;
        mp0 = mul_pulses;
        dp0 = div_pulses;
        start_op(op, a, b, rd, lat);
        if (spur) begin
            if (op[2]) spur_mul = 1;
            else spur_div = 1;
        end
        k = 0;
        rr_bad = 0;
        while (!ifc.rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
            if (ifc.req_ready) rr_bad = 1;
        end
        chk("latency", k, lat + 1);
        chk("ready_low", rr_bad, 0);
        chk("rsp_result", ifc.rsp_result, ref_md(op, a, b));
        chk("rsp_rd", ifc.rsp_rd, rd);
        r0 = ifc.rsp_result;
        d0 = ifc.rsp_rd;
        hold_ok = 1;
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            if (!ifc.rsp_valid || ifc.rsp_result !== r0 ||
                ifc.rsp_rd !== d0 || ifc.req_ready)
                hold_ok = 0;
        end
        if (rdelay > 0) chk("bp_hold", hold_ok, 1);
        finish_rsp();
        chk("mul_pulses", mul_pulses - mp0, op[2] ? 0 : 1);
        chk("div_pulses", div_pulses - dp0, op[2] ? 1 : 0);
    endtask

    task automatic flush_op(input logic [2:0] op, input int lat,
                            input int fk);
        int k;
        bit seen;
        start_op(op, 32'd1000, 32'd9, 5'd3, lat);
        k = 0;
        seen = 0;
        while (busy && k < 200) begin
            flush = (k == fk);
            @(negedge clk);
            k++;
            if (ifc.rsp_valid) seen = 1;
        end
        flush = 1'b0;
        chk("flush_no_rsp", seen, 0);
        chk("flush_idle_at", k, lat + 1);
        chk("flush_ready", ifc.req_ready, 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", ifc.req_ready, 1);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_result", ifc.rsp_result, 0);
        chk("rst_rsp_rd", ifc.rsp_rd, 0);
        chk("rst_pulses", {mul_valid, div_valid}, 0);
        chk("rst_opnds", {mul_a, div_divisor, mul_optype}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [2:0] op;
        logic [31:0] a, b;
        ifc.req_valid  = 1'b0;
        ifc.req_optype = '0;
        ifc.req_a      = '0;
        ifc.req_b      = '0;
        ifc.req_rd     = '0;
        ifc.rsp_ready  = 1'b0;
        flush          = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rstb = 1'b1;
        @(negedge clk);
        chk_reset_state();

        do_op(OP_MUL, 32'd7, -32'sd3, 5'd5, 2, 0, 0);
        do_op(OP_DIVU, 32'd100, 32'd7, 5'd9, 4, 0, 0);
        do_op(OP_REMU, 32'd100, 32'd7, 5'd10, 4, 0, 0);
        do_op(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1, 10, 0);

        flush_op(OP_DIV, 12, 5);
        flush_op(OP_DIVU, 3, 0);
        do_op(OP_MUL, 32'd6, 32'd7, 5'd12, 3, 0, 0);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                ifc.req_valid = 1'b1;
                ifc.req_optype = op;
                flush = 1'b1;
                @(posedge clk);
                @(negedge clk);
                ifc.req_valid = 1'b0;
                flush = 1'b0;
                chk("idle_flush_busy", busy, 0);
                chk("idle_flush_pulse", {mul_valid, div_valid}, 0);
            end
            do_op(op, a, b, 5'($urandom), $urandom_range(1, 6),
                  $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        div_hang = 1;
        start_op(OP_DIVU, 32'd50, 32'd5, 5'd17, 1);
        k = 0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycle", k, TO);
        chk("tmo_rsp_valid", ifc.rsp_valid, 1);
        chk("tmo_result", ifc.rsp_result, 0);
        chk("tmo_rd", ifc.rsp_rd, 17);
        finish_rsp();
        div_hang = 0;
        chk("tmo_err_sticky", err, 1);
        do_op(OP_MUL, 32'd3, 32'd5, 5'd2, 2, 0, 0);
        chk("tmo_err_still", err, 1);

        start_op(OP_MUL, 32'd11, 32'd13, 5'd7, 10);
        repeat (3) @(negedge clk);
        #2 rstb = 1'b0;
        #1 chk_reset_state();
        @(negedge clk);
        rstb = 1'b1;
        do_op(OP_MUL, 32'd7, -32'sd3, 5'd5, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
